ascon_permutation_unrolled: RTL and testbench

Parametrised, FSM-driven Ascon permutation core: applies p12 or p6 to a 320-bit state, computing UNROLL rounds per clock. It supports an optional rate XOR on x0 before the first round and a key XOR on x1..x4 after the last round. A start/busy/done handshake replaces the external round counter and mux select. It sits between the Ascon-128 control FSM and the state register path, and is the drop-in successor of the single-round permutation-with-XOR datapath.

---
 rtl/ascon_permutation_unrolled.sv | 177 +++++++++++++++++
 tb/tb_ascon_permutation_unrolled.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_permutation_unrolled.sv
// ascon_permutation_unrolled
//   Ascon permutation core (p12 / p6) on a 320-bit state {x0,x1,x2,x3,x4},
//   computing UNROLL rounds per clock under a start/busy/done handshake.
//   An optional rate XOR into x0 is applied before the first round. An
//   optional key XOR into x1..x4 is applied after round 11.
//
//   Parameter UNROLL : rounds per clock, one of 1, 2, 3, 6.
//   Macro ASCON_XOR_DOWN_EN : when defined, the key XOR datapath, its
//     capture register and the data_xor_down_i/ena_xor_down_i ports exist.
//
//   Ports
//     clock_i          rising-edge clock
//     resetb_i         asynchronous active-low reset
//     start_i          start request, accepted in IDLE or DONE
//     mode_i           0 = p12 (rounds 0..11), 1 = p6 (rounds 6..11)
//     state_i          initial state, x0 in [319:256]
//     data_xor_up_i    rate word XORed into x0 before the first round
//     ena_xor_up_i     enable for the rate XOR
//     data_xor_down_i  key XORed into x1..x4 after round 11 (macro only)
//     ena_xor_down_i   enable for the key XOR (macro only)
//     busy_o           permutation in progress
//     done_o           one-cycle pulse, state_o holds the result
//     state_o          state register
module ascon_permutation_unrolled #(
  parameter int unsigned UNROLL = 1
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic         mode_i,
  input  logic [319:0] state_i,
  input  logic [63:0]  data_xor_up_i,
  input  logic         ena_xor_up_i,
`ifdef ASCON_XOR_DOWN_EN
  input  logic [255:0] data_xor_down_i,
  input  logic         ena_xor_down_i,
`endif
  output logic         busy_o,
  output logic         done_o,
  output logic [319:0] state_o
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 6)) begin : g_bad_unroll
    $error("ascon_permutation_unrolled: UNROLL must be 1, 2, 3 or 6");
  end

  localparam logic [3:0] UNROLL_W = 4'(UNROLL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [319:0] state_q, state_d;
  logic [319:0] chain;
  logic         accept;
  logic         load;
  logic         last_grp;
  logic [3:0]   base_round;
  logic [3:0]   last_round;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128];
    x3 = s[127:64];
    x4 = s[63:0];
    x2[7:0] = x2[7:0] ^ {4'hf - r, r};
    // bit-sliced 5-bit S-box
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    // linear diffusion
    x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

`ifdef ASCON_XOR_DOWN_EN
  logic [255:0] key_q;
  logic         key_en_q;
  logic [255:0] down_key;
  logic         down_en;

  // On the accepting edge the group may already contain round 11 (p6 with
  // UNROLL=6), so the live inputs are used instead of the capture register.
  assign down_key = accept ? data_xor_down_i : key_q;
  assign down_en  = accept ? ena_xor_down_i  : key_en_q;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      key_q    <= '0;
      key_en_q <= 1'b0;
    end else if (accept) begin
      key_q    <= data_xor_down_i;
      key_en_q <= ena_xor_down_i;
    end
  end
`endif

  // Datapath: input mux, optional rate XOR, UNROLL chained rounds, optional key XOR.
  always_comb begin
    accept     = start_i && (fsm_q != S_RUN);
    load       = accept || (fsm_q == S_RUN);
    base_round = accept ? (mode_i ? 4'd6 : 4'd0) : round_q;
    last_round = base_round + UNROLL_W - 4'd1;
    last_grp   = (last_round == 4'd11);

    chain = accept ? state_i : state_q;
    if (accept && ena_xor_up_i) begin
      chain[319:256] = chain[319:256] ^ data_xor_up_i;
    end
    for (int unsigned k = 0; k < UNROLL; k++) begin
      chain = ascon_round(chain, base_round + 4'(k));
    end
`ifdef ASCON_XOR_DOWN_EN
    if (last_grp && down_en) begin
      chain[255:0] = chain[255:0] ^ down_key;
    end
`endif
    state_d = load ? chain : state_q;
  end

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    if (load) begin
      round_d = base_round + UNROLL_W;
      fsm_d   = last_grp ? S_DONE : S_RUN;
    end else if (fsm_q == S_DONE) begin
      fsm_d = S_IDLE;
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= S_IDLE;
      round_q <= '0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
    end
  end

  assign busy_o  = (fsm_q == S_RUN);
  assign done_o  = (fsm_q == S_DONE);
  assign state_o = state_q;

endmodule

// File: tb/tb_ascon_permutation_unrolled.sv
// Bench for ascon_permutation_unrolled: four instances (UNROLL 1/2/3/6) share
// one stimulus stream; each result is checked against constants or a
// table-driven reference model, together with done/busy timing.
module tb_ascon_permutation_unrolled;

`ifdef ASCON_XOR_DOWN_EN
  localparam bit HAS_DOWN = 1'b1;
`else
  localparam bit HAS_DOWN = 1'b0;
`endif

  typedef struct {
    logic         mode;
    logic [319:0] st;
    logic         upen;
    logic [63:0]  up;
    logic         dnen;
    logic [255:0] dn;
    logic [319:0] exp;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         mode;
  logic [319:0] st_in;
  logic [63:0]  up;
  logic         upen;
  logic [255:0] dn;
  logic         dnen;
  logic [3:0]   done_w;
  logic [3:0]   busy_w;
  logic [319:0] st_w [4];

  int n_tests = 0;
  int n_fail  = 0;

  vec_t vecs [5];

  ascon_permutation_unrolled #(.UNROLL(1)) u1 (
    .clock_i(clk), .resetb_i(rst_n), .start_i(start), .mode_i(mode), .state_i(st_in),
    .data_xor_up_i(up), .ena_xor_up_i(upen),
`ifdef ASCON_XOR_DOWN_EN
    .data_xor_down_i(dn), .ena_xor_down_i(dnen),
`endif
    .busy_o(busy_w[0]), .done_o(done_w[0]), .state_o(st_w[0]));

  ascon_permutation_unrolled #(.UNROLL(2)) u2 (
    .clock_i(clk), .resetb_i(rst_n), .start_i(start), .mode_i(mode), .state_i(st_in),
    .data_xor_up_i(up), .ena_xor_up_i(upen),
`ifdef ASCON_XOR_DOWN_EN
    .data_xor_down_i(dn), .ena_xor_down_i(dnen),
`endif
    .busy_o(busy_w[1]), .done_o(done_w[1]), .state_o(st_w[1]));

  ascon_permutation_unrolled #(.UNROLL(3)) u3 (
    .clock_i(clk), .resetb_i(rst_n), .start_i(start), .mode_i(mode), .state_i(st_in),
    .data_xor_up_i(up), .ena_xor_up_i(upen),
`ifdef ASCON_XOR_DOWN_EN
    .data_xor_down_i(dn), .ena_xor_down_i(dnen),
`endif
    .busy_o(busy_w[2]), .done_o(done_w[2]), .state_o(st_w[2]));

  ascon_permutation_unrolled #(.UNROLL(6)) u6 (
    .clock_i(clk), .resetb_i(rst_n), .start_i(start), .mode_i(mode), .state_i(st_in),
    .data_xor_up_i(up), .ena_xor_up_i(upen),
`ifdef ASCON_XOR_DOWN_EN
    .data_xor_down_i(dn), .ena_xor_down_i(dnen),
`endif
    .busy_o(busy_w[3]), .done_o(done_w[3]), .state_o(st_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (S-box by lookup table) ----------------
  function automatic logic [4:0] sbox(input logic [4:0] v);
    case (v)
      5'd0:  return 5'h04; 5'd1:  return 5'h0b; 5'd2:  return 5'h1f; 5'd3:  return 5'h14;
      5'd4:  return 5'h1a; 5'd5:  return 5'h15; 5'd6:  return 5'h09; 5'd7:  return 5'h02;
      5'd8:  return 5'h1b; 5'd9:  return 5'h05; 5'd10: return 5'h08; 5'd11: return 5'h12;
      5'd12: return 5'h1d; 5'd13: return 5'h03; 5'd14: return 5'h06; 5'd15: return 5'h1c;
      5'd16: return 5'h1e; 5'd17: return 5'h13; 5'd18: return 5'h07; 5'd19: return 5'h0e;
      5'd20: return 5'h00; 5'd21: return 5'h0d; 5'd22: return 5'h11; 5'd23: return 5'h18;
      5'd24: return 5'h10; 5'd25: return 5'h0c; 5'd26: return 5'h01; 5'd27: return 5'h19;
      5'd28: return 5'h16; 5'd29: return 5'h0a; 5'd30: return 5'h0f; default: return 5'h17;
    endcase
  endfunction

  function automatic logic [63:0] rr(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v} >> n;
    return d[63:0];
  endfunction

  function automatic logic [319:0] model_round(input logic [319:0] s, input int r);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  idx;
    logic [4:0]  o;
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
    x[2][7:0] = x[2][7:0] ^ 8'((15 - r) * 16 + r);
    for (int b = 0; b < 64; b++) begin
      idx = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      o = sbox(idx);
      for (int i = 0; i < 5; i++) y[i][b] = o[4 - i];
    end
    return {y[0] ^ rr(y[0], 19) ^ rr(y[0], 28),
            y[1] ^ rr(y[1], 61) ^ rr(y[1], 39),
            y[2] ^ rr(y[2], 1)  ^ rr(y[2], 6),
            y[3] ^ rr(y[3], 10) ^ rr(y[3], 17),
            y[4] ^ rr(y[4], 7)  ^ rr(y[4], 41)};
  endfunction

  function automatic logic [319:0] model_perm(input vec_t v);
    logic [319:0] s;
    s = v.st;
    if (v.upen) s[319:256] = s[319:256] ^ v.up;
    for (int r = (v.mode ? 6 : 0); r < 12; r++) s = model_round(s, r);
    if (HAS_DOWN && v.dnen) s[255:0] = s[255:0] ^ v.dn;
    return s;
  endfunction

  function automatic int exp_n(input int u, input logic m);
    int unr;
    case (u)
      0: unr = 1;
      1: unr = 2;
      2: unr = 3;
      default: unr = 6;
    endcase
    return (m ? 6 : 12) / unr;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check_vec(input string name, input logic [319:0] got, input logic [319:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Start one permutation on all instances, scramble every start-sampled
  // input right after the accepting edge, then watch 14 cycles.
  task automatic run_vec(input vec_t v, input int id);
    int           cyc  [4];
    int           bsy1 [4];
    logic [319:0] got  [4];
    @(negedge clk);
    start = 1'b1; mode = v.mode; st_in = v.st; up = v.up; upen = v.upen;
    dn = v.dn; dnen = v.dnen;
    @(posedge clk);
    #1;
    start = 1'b0; mode = ~v.mode; st_in = ~v.st; up = ~v.up; upen = ~v.upen;
    dn = ~v.dn; dnen = ~v.dnen;
    for (int u = 0; u < 4; u++) begin
      cyc[u] = 0; bsy1[u] = 0; got[u] = '0;
    end
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      for (int u = 0; u < 4; u++) begin
        if (c == 1) bsy1[u] = int'(busy_w[u]);
        if (cyc[u] == 0 && done_w[u]) begin
          cyc[u] = c;
          got[u] = st_w[u];
        end
      end
    end
    for (int u = 0; u < 4; u++) begin
      check_int($sformatf("v%0d_u%0d_done_cycle", id, u), cyc[u], exp_n(u, v.mode));
      check_int($sformatf("v%0d_u%0d_busy_after_E0", id, u), bsy1[u],
                (exp_n(u, v.mode) > 1) ? 1 : 0);
      check_vec($sformatf("v%0d_u%0d_result", id, u), got[u], v.exp);
    end
    check_vec($sformatf("v%0d_u0_hold_idle", id), st_w[0], v.exp);
    start = 1'b0; mode = 1'b0; st_in = '0; up = '0; upen = 1'b0; dn = '0; dnen = 1'b0;
  endtask

  initial begin
    int done_seen;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; st_in = '0;
    up = '0; upen = 1'b0; dn = '0; dnen = 1'b0;

    vecs[0].mode = 1'b0; vecs[0].st = {64'h00400c0000000100, 256'h0};
    vecs[0].upen = 1'b0; vecs[0].up = '0; vecs[0].dnen = 1'b0; vecs[0].dn = '0;
    vecs[0].exp = {64'hee9398aadb67f03d, 64'h8bb21831c60f1002, 64'hb48a92db98d5da62,
                   64'h43189921b8f8e3e8, 64'h348fa5c9d525e140};

    vecs[1].mode = 1'b1;
    vecs[1].st = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h3c5a96f01e2d4b87,
                  64'h9e3779b97f4a7c15, 64'hd1b54a32d192ed03};
    vecs[1].upen = 1'b1; vecs[1].up = 64'ha5a5a5a5a5a5a5a5;
    vecs[1].dnen = 1'b1;
    vecs[1].dn = {64'h0f1e2d3c4b5a6978, 64'h8796a5b4c3d2e1f0, 64'h1122334455667788,
                  64'h99aabbccddeeff00};

    vecs[2].mode = 1'b0;
    vecs[2].st = {64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b,
                  64'ha54ff53a5f1d36f1, 64'h510e527fade682d1};
    vecs[2].upen = 1'b1; vecs[2].up = 64'h8000000000000001;
    vecs[2].dnen = 1'b0; vecs[2].dn = {4{64'hdeadbeefcafef00d}};

    vecs[3].mode = 1'b1; vecs[3].st = '1;
    vecs[3].upen = 1'b0; vecs[3].up = '0; vecs[3].dnen = 1'b0; vecs[3].dn = '0;

    vecs[4].mode = 1'b0; vecs[4].st = '0;
    vecs[4].upen = 1'b0; vecs[4].up = 64'h1; vecs[4].dnen = 1'b1;
    vecs[4].dn = {64'h0001020304050607, 64'h08090a0b0c0d0e0f, 64'h1011121314151617,
                  64'h18191a1b1c1d1e1f};

    for (int i = 1; i < 5; i++) vecs[i].exp = model_perm(vecs[i]);

    // reset state
    repeat (3) @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      check_int($sformatf("rst_u%0d_busy", u), int'(busy_w[u]), 0);
      check_int($sformatf("rst_u%0d_done", u), int'(done_w[u]), 0);
      check_vec($sformatf("rst_u%0d_state", u), st_w[u], '0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // back-to-back: start held high, p6, UNROLL=3 -> done every 2 cycles
    @(negedge clk);
    start = 1'b1; mode = 1'b1; st_in = vecs[3].st;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check_int($sformatf("b2b_c%0d_done", c), int'(done_w[2]), (c % 2 == 0) ? 1 : 0);
      if (c % 2 == 0) check_vec($sformatf("b2b_c%0d_result", c), st_w[2], vecs[3].exp);
    end
    start = 1'b0;
    repeat (16) @(negedge clk);

    // reset during RUN: asynchronous clear, no done for the aborted run
    start = 1'b1; mode = 1'b0; st_in = vecs[0].st;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int u = 0; u < 4; u++) begin
      check_int($sformatf("midrst_u%0d_busy", u), int'(busy_w[u]), 0);
      check_int($sformatf("midrst_u%0d_done", u), int'(done_w[u]), 0);
      check_vec($sformatf("midrst_u%0d_state", u), st_w[u], '0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (done_w != 4'b0) done_seen++;
    end
    check_int("midrst_no_done", done_seen, 0);
    run_vec(vecs[1], 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
